axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI4-Lite read and write transactions, and returns each result on a valid/ready response stream. It sits directly upstream of the Arty A7 GPIO slave and drives its s_axi_* channels. Debug sequencers and the UART command front-end use it to configure LEDs, RGB PWM and config registers and to read the switch and button counters without handling AXI channel handshakes themselves.

## Interface
- ADDR_W, 32, width of cmd_addr / m_axi_awaddr / m_axi_araddr
- m_axi_aclk  in  1  bus clock; all logic on rising edge
- m_axi_aresetn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address, passed to the bus unmodified (no alignment)
- cmd_wdata / cmd_wstrb  in  32 / 4  write data and byte strobes; ignored for reads
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_write  out  1  echoes cmd_write of the completed command
- rsp_data  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP of the transaction
- m_axi_aw{addr,prot,valid,ready}  out,out,out,in  ADDR_W,3,1,1  write address channel; prot is constant 3'b000
- m_axi_w{data,strb,valid,ready}  out,out,out,in  32,4,1,1  write data channel
- m_axi_b{resp,valid,ready}  in,in,out  2,1,1  write response channel
- m_axi_ar{addr,prot,valid,ready}  out,out,out,in  ADDR_W,3,1,1  read address channel; prot is constant 3'b000
- m_axi_r{data,resp,valid,ready}  in,in,in,out  32,2,1,1  read data channel

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, the FSM registers addr, data, strb and write, then moves to WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid assert together. Each valid stays high until its own handshake completes, tracked by the aw_done and w_done flags. Either handshake may complete first, or both in the same cycle. When both are done, the FSM moves to WR_RESP.
- WR_RESP: bready=1. On bvalid, the FSM latches bresp, sets rsp_data=0 and moves to RSP.
- RD_REQ: arvalid=1 until arready, then the FSM moves to RD_DATA.
- RD_DATA: rready=1. On rvalid, the FSM latches rdata and rresp and moves to RSP.
- RSP: rsp_valid=1 with rsp_* stable until rsp_ready, then the FSM returns to IDLE.
- Only one transaction is ever outstanding. cmd_ready=0 in every state except IDLE.
- Every AXI valid is registered and never deasserts before its ready. Address and data are stable while valid is high.
- bready is 1 only in WR_RESP and rready is 1 only in RD_DATA. A bvalid or rvalid arriving in any other state is held off by the slave.
- Error responses (SLVERR 2'b10, DECERR 2'b11) are passed through unchanged. There is no retry.
- Reset, asserted at any time and in any state: the FSM goes to IDLE and the transaction in flight is abandoned with no response. All valids, bready and rready go to 0 immediately (asynchronously). On release, cmd_ready=1 on the first clock edge.
- Reset values: cmd_ready=0 during reset and 1 after release; rsp_valid=0; rsp_write=0; rsp_data=0; rsp_resp=0; all m_axi valid/ready outputs 0; addr/data/strb outputs 0; prot outputs 0.

## Timing
- Write with an always-ready slave:
  - cycle 0: command accepted.
  - cycle 1: awvalid and wvalid high; handshake completes.
  - cycle 2: bready high; bvalid sampled in cycle 2 or later.
  - rsp_valid asserts 1 cycle after the B handshake.
- Read follows the same pattern: arvalid in cycle 1, rready from cycle 2, rsp_valid 1 cycle after the R handshake.
- Minimum command-to-response latency is 3 cycles. A new command can be accepted the cycle after the rsp handshake.

## Configuration
- AXI_CMD_MASTER_STATS_EN defined: the block adds outputs txn_count[15:0] and err_count[15:0].
  - txn_count increments on every completed B or R handshake.
  - err_count increments when that handshake's resp[1] is 1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Macro undefined: the block has no counters and no such ports.

## Structure
- The shared package axi_lite_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - the FSM state typedef.
  - the GPIO register offset constants 0x00–0x30 used by benches.
- Sub-module: axi_sat_counter (16-bit saturating counter with enable), instantiated twice when stats are enabled.

## Test plan
- Write cmd addr 0x008, data 5, strb 4'hF to an always-ready slave -> awaddr=0x008 and wdata=5 in cycle 1; rsp_valid in cycle 3 with rsp_write=1, rsp_resp=2'b00, rsp_data=0.
- Read cmd addr 0x00C; slave returns rdata 0xA, OKAY -> rsp_data=0xA, rsp_resp=2'b00, rsp_write=0.
- Slave delays awready by 3 cycles while wready is immediate -> wvalid high for 1 cycle, awvalid high for 4 cycles, exactly one B accepted, one response produced.
- Read addr 0x00D; slave returns SLVERR -> rsp_resp=2'b10; with the STATS macro defined, err_count 0->1 and txn_count increments.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp_data held stable, cmd_ready=0 throughout, a second cmd_valid is not accepted until after the rsp handshake.
- Reset asserted in RD_DATA -> arvalid and rready 0 immediately, rsp_valid never asserts for that command, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
//   Shared definitions for the AXI4-Lite command master and the benches that
//   drive the Arty A7 GPIO slave:
//     - AXI response codes (RESP_*)
//     - command-master FSM state type and state encodings (ST_*)
//     - GPIO slave register byte offsets (GPIO_REG_*), 0x00 .. 0x30
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_REQ  = 3'd1;
    localparam state_t ST_WR_RESP = 3'd2;
    localparam state_t ST_RD_REQ  = 3'd3;
    localparam state_t ST_RD_DATA = 3'd4;
    localparam state_t ST_RSP     = 3'd5;

    localparam logic [31:0] GPIO_REG_LED       = 32'h00;
    localparam logic [31:0] GPIO_REG_RGB0_PWM  = 32'h04;
    localparam logic [31:0] GPIO_REG_RGB1_PWM  = 32'h08;
    localparam logic [31:0] GPIO_REG_CONFIG    = 32'h0C;
    localparam logic [31:0] GPIO_REG_SWITCHES  = 32'h10;
    localparam logic [31:0] GPIO_REG_BUTTONS   = 32'h14;
    localparam logic [31:0] GPIO_REG_SW_CNT0   = 32'h18;
    localparam logic [31:0] GPIO_REG_SW_CNT1   = 32'h1C;
    localparam logic [31:0] GPIO_REG_BTN_CNT0  = 32'h20;
    localparam logic [31:0] GPIO_REG_BTN_CNT1  = 32'h24;
    localparam logic [31:0] GPIO_REG_IRQ_MASK  = 32'h28;
    localparam logic [31:0] GPIO_REG_IRQ_STAT  = 32'h2C;
    localparam logic [31:0] GPIO_REG_VERSION   = 32'h30;

endpackage

// File: rtl/axi_sat_counter.sv
// axi_sat_counter
//   16-bit event counter that sticks at 16'hFFFF instead of wrapping.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset, clears count
//     en     in   count one event this cycle
//     count  out  current count
module axi_sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   Single-outstanding AXI4-Lite master. Accepts one command on the cmd
//   stream, runs the matching AXI4-Lite write or read, and returns the result
//   on the rsp stream before accepting the next command.
//
//   Handshakes: every valid/ready pair transfers on a rising edge where both
//   are 1. A valid driven by this block is registered, stays high until its
//   ready is seen, and its payload is stable while it is high.
//
//   Ports:
//     m_axi_aclk, m_axi_aresetn    clock / asynchronous active-low reset
//     cmd_valid/ready, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb
//                                  command stream (wdata/wstrb unused for reads)
//     rsp_valid/ready, rsp_write, rsp_data, rsp_resp
//                                  response stream (rsp_data is 0 for writes)
//     m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*
//                                  AXI4-Lite master channels, prot fixed at 0
//     state_dbg                    current FSM state (axi_lite_pkg::ST_*)
//     txn_count, err_count         only with AXI_CMD_MASTER_STATS_EN defined:
//                                  saturating counts of completed B/R
//                                  handshakes and of those with resp[1]=1
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_resp,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,

    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,

    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    output logic [2:0]        state_dbg
`ifdef AXI_CMD_MASTER_STATS_EN
    ,
    output logic [15:0]       txn_count,
    output logic [15:0]       err_count
`endif
);

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_fin;
    logic   w_fin;

    // A channel counts as finished if it completed earlier or completes now,
    // so AW and W may finish in either order or in the same cycle.
    always_comb begin
        aw_fin = aw_done || (m_axi_awvalid && m_axi_awready);
        w_fin  = w_done  || (m_axi_wvalid  && m_axi_wready);
    end

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign state_dbg    = state;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_data      <= 32'h0;
            rsp_resp      <= 2'b00;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= 32'h0;
            m_axi_wstrb   <= 4'h0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // cmd_ready is low out of reset and rises on the first edge.
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WR_REQ;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_data     <= 32'h0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end

                ST_RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end

                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_data     <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encodings: drop every request and recover.
                    cmd_ready     <= 1'b0;
                    rsp_valid     <= 1'b0;
                    m_axi_awvalid <= 1'b0;
                    m_axi_wvalid  <= 1'b0;
                    m_axi_bready  <= 1'b0;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_CMD_MASTER_STATS_EN
    logic b_hs;
    logic r_hs;
    logic txn_hit;
    logic err_hit;

    always_comb begin
        b_hs    = m_axi_bvalid && m_axi_bready;
        r_hs    = m_axi_rvalid && m_axi_rready;
        txn_hit = b_hs || r_hs;
        err_hit = (b_hs && m_axi_bresp[1]) || (r_hs && m_axi_rresp[1]);
    end

    axi_sat_counter u_txn_count (
        .clk   (m_axi_aclk),
        .rst_n (m_axi_aresetn),
        .en    (txn_hit),
        .count (txn_count)
    );

    axi_sat_counter u_err_count (
        .clk   (m_axi_aclk),
        .rst_n (m_axi_aresetn),
        .en    (err_hit),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master
//   Bench for axi_lite_cmd_master. A behavioural AXI4-Lite slave with
//   programmable per-channel ready/valid delays and response codes sits on the
//   m_axi side. Each command pushes its expected response into exp_q; the
//   monitor pops and compares on every rsp handshake.
//   Define AXI_CMD_MASTER_STATS_EN to also check txn_count / err_count.
module tb_axi_lite_cmd_master;
    import axi_lite_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [2:0]  state_dbg;
`ifdef AXI_CMD_MASTER_STATS_EN
    logic [15:0] txn_count, err_count;
`endif

    axi_lite_cmd_master #(.ADDR_W(32)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_data      (rsp_data),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .state_dbg     (state_dbg)
`ifdef AXI_CMD_MASTER_STATS_EN
        ,
        .txn_count     (txn_count),
        .err_count     (err_count)
`endif
    );

    // ---------------- checking ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- slave model configuration ----------------
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  b_resp_cfg = RESP_OKAY;
    logic [1:0]  r_resp_cfg = RESP_OKAY;
    logic [31:0] r_data_cfg = 32'h0;
    int          rsp_ready_mode = 0;   // 0: always 1, 1: held low, 2: random

    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    // Slave reacts 2 time units after each rising edge, after the DUT has
    // updated its registered outputs.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            rsp_ready = 1'b1;
        end else begin
            if (awready && !awvalid) begin awready = 1'b0; aw_cnt = 0; end
            else if (awvalid && !awready) begin
                if (aw_cnt >= aw_delay) awready = 1'b1; else aw_cnt++;
            end
            if (wready && !wvalid) begin wready = 1'b0; w_cnt = 0; end
            else if (wvalid && !wready) begin
                if (w_cnt >= w_delay) wready = 1'b1; else w_cnt++;
            end
            if (arready && !arvalid) begin arready = 1'b0; ar_cnt = 0; end
            else if (arvalid && !arready) begin
                if (ar_cnt >= ar_delay) arready = 1'b1; else ar_cnt++;
            end
            if (bvalid && !bready) bvalid = 1'b0;
            else if (bready && !bvalid) begin
                if (b_cnt >= b_delay) begin bvalid = 1'b1; bresp = b_resp_cfg; b_cnt = 0; end
                else b_cnt++;
            end
            if (rvalid && !rready) rvalid = 1'b0;
            else if (rready && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid = 1'b1; rdata = r_data_cfg; rresp = r_resp_cfg; r_cnt = 0;
                end else r_cnt++;
            end
            case (rsp_ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [34:0] exp_q[$];     // {write, resp[1:0], data[31:0]}
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;
    int          exp_lat = 0;  // 0: latency not checked
    int          exp_txn = 0, exp_err = 0;

    int   accept_cyc = 0, rsp_hs_cyc = 0;
    int   aw_cycles = 0, w_cycles = 0, b_count = 0, r_count = 0, rsp_count = 0;
    logic prev_rsp_valid = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) accept_cyc = cyc;
            if (awvalid) aw_cycles++;
            if (wvalid)  w_cycles++;
            if (awvalid && awready) begin
                check("awaddr", awaddr, exp_addr);
                check("awprot", awprot, 0);
            end
            if (wvalid && wready) begin
                check("wdata", wdata, exp_wdata);
                check("wstrb", wstrb, exp_wstrb);
            end
            if (arvalid && arready) begin
                check("araddr", araddr, exp_addr);
                check("arprot", arprot, 0);
            end
            if (bvalid && bready) b_count++;
            if (rvalid && rready) r_count++;
            if (rsp_valid && !prev_rsp_valid && exp_lat != 0)
                check("latency", 64'(cyc - accept_cyc), 64'(exp_lat));
            if (rsp_valid && rsp_ready) begin
                logic [34:0] item;
                rsp_count++;
                rsp_hs_cyc = cyc;
                check("rsp_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    item = exp_q.pop_front();
                    check("rsp_write", rsp_write, item[34]);
                    check("rsp_resp",  rsp_resp,  item[33:32]);
                    check("rsp_data",  rsp_data,  item[31:0]);
                end
            end
            prev_rsp_valid = rsp_valid;
        end else begin
            prev_rsp_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [31:0] exp_data,
                             input logic [1:0] exp_resp, input bit expect_rsp);
        int n;
        @(posedge clk); #1;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
        if (expect_rsp) begin
            exp_q.push_back({wr, exp_resp, exp_data});
            exp_txn++;
            if (exp_resp[1]) exp_err++;
        end
        cmd_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
        check("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("rsp_pending", 64'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        aw_cycles = 0; w_cycles = 0; b_count = 0; r_count = 0; rsp_count = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0; rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_data",  rsp_data, 0);
        check("rst_rsp_resp",  rsp_resp, 0);
        check("rst_valids",    {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_addr_data", {awaddr, araddr, wdata, 28'h0, wstrb}, 0);
        check("rst_prot",      {awprot, arprot}, 0);
`ifdef AXI_CMD_MASTER_STATS_EN
        check("rst_counts", {txn_count, err_count}, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_cmd_ready", cmd_ready, 1);

        // Write, always-ready slave
        clear_counts();
        exp_lat = 3;
        drive_cmd(1'b1, GPIO_REG_RGB1_PWM, 32'h5, 4'hF, 32'h0, RESP_OKAY, 1'b1);
        wait_rsp();
        check("wr_aw_cycles", 64'(aw_cycles), 1);
        check("wr_b_count",   64'(b_count), 1);

        // Read, always-ready slave
        r_data_cfg = 32'hA; r_resp_cfg = RESP_OKAY;
        drive_cmd(1'b0, GPIO_REG_CONFIG, 32'h0, 4'h0, 32'hA, RESP_OKAY, 1'b1);
        wait_rsp();

        // awready delayed 3 cycles, wready immediate
        clear_counts();
        exp_lat = 0;
        aw_delay = 3;
        drive_cmd(1'b1, GPIO_REG_LED, 32'h1234_5678, 4'h3, 32'h0, RESP_OKAY, 1'b1);
        wait_rsp();
        aw_delay = 0;
        check("awd_aw_cycles", 64'(aw_cycles), 4);
        check("awd_w_cycles",  64'(w_cycles), 1);
        check("awd_b_count",   64'(b_count), 1);
        check("awd_rsp_count", 64'(rsp_count), 1);

        // Read to unaligned address, SLVERR
        r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = RESP_SLVERR;
        drive_cmd(1'b0, 32'h0000_000D, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_SLVERR, 1'b1);
        wait_rsp();
`ifdef AXI_CMD_MASTER_STATS_EN
        check("slverr_err_count", err_count, 1);
        check("slverr_txn_count", txn_count, 64'(exp_txn));
`endif

        // Response back-pressure: rsp_ready low for 5 cycles
        r_data_cfg = 32'h5A5A; r_resp_cfg = RESP_OKAY;
        rsp_ready_mode = 1;
        drive_cmd(1'b0, GPIO_REG_SWITCHES, 32'h0, 4'h0, 32'h5A5A, RESP_OKAY, 1'b1);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
            check("bp_rsp_valid_seen", rsp_valid, 1);
            @(posedge clk); #1;
            cmd_write = 1'b1; cmd_addr = GPIO_REG_RGB0_PWM; cmd_wdata = 32'h3; cmd_wstrb = 4'h1;
            exp_addr = GPIO_REG_RGB0_PWM; exp_wdata = 32'h3; exp_wstrb = 4'h1;
            exp_q.push_back({1'b1, RESP_OKAY, 32'h0});
            exp_txn++;
            cmd_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_data",  rsp_data, 32'h5A5A);
                check("bp_cmd_ready", cmd_ready, 0);
            end
            @(posedge clk); #1;
            rsp_ready_mode = 0;
            n = 0;
            do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
            check("bp_second_accept", cmd_ready, 1);
            check("bp_accept_cycle", 64'(cyc - rsp_hs_cyc), 1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        wait_rsp();

        // Reset while waiting in RD_DATA
        r_delay = 1000;
        clear_counts();
        drive_cmd(1'b0, GPIO_REG_BUTTONS, 32'h0, 4'h0, 32'h0, RESP_OKAY, 1'b0);
        begin
            int n;
            n = 0;
            while (!rready && n < 50) begin @(negedge clk); n++; end
            check("rst_mid_rready_seen", rready, 1);
            @(posedge clk); #3;
            rst_n = 1'b0;
            #1;
            check("rst_mid_arvalid", arvalid, 0);
            check("rst_mid_rready",  rready, 0);
            check("rst_mid_cmd_ready", cmd_ready, 0);
            exp_txn = 0; exp_err = 0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            r_delay = 0;
            @(posedge clk); #1;
            check("rst_mid_rel_cmd_ready", cmd_ready, 1);
`ifdef AXI_CMD_MASTER_STATS_EN
            check("rst_mid_counts", {txn_count, err_count}, 0);
`endif
            repeat (10) @(negedge clk);
            check("rst_mid_no_rsp", 64'(rsp_count), 0);
        end

        // Random traffic with random delays, responses and back-pressure
        rsp_ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            logic        wr;
            logic [31:0] addr, data;
            logic [3:0]  strb;
            logic [1:0]  resp;
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 63));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            resp = 2'($urandom_range(0, 3));
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            b_resp_cfg = resp; r_resp_cfg = resp; r_data_cfg = data ^ 32'hFFFF_0000;
            drive_cmd(wr, addr, data, strb, wr ? 32'h0 : (data ^ 32'hFFFF_0000), resp, 1'b1);
            wait_rsp();
        end
        rsp_ready_mode = 0;
`ifdef AXI_CMD_MASTER_STATS_EN
        check("final_txn_count", txn_count, 64'(exp_txn));
        check("final_err_count", err_count, 64'(exp_err));
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        tests_run++;
        tests_failed++;
        $display("FAIL timeout got=running exp=finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
